div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Iterative RV32M divider (DIV/DIVU/REM/REMU) in the Execute stage, beside the ALU.
//  - Result is muxed into ALUResultE ahead of ex_mem_reg.
//  - Stalls IF/ID/EX while iterating; the instruction advances into EX/MEM on the DivDoneE cycle.
//  - Radix-2 restoring algorithm: 1 quotient bit per cycle.
// PARAMETERS
//  XLEN     32  operand/result width (only 32 supported)
//  CNT_W    5   iteration counter width, log2(XLEN)
// PORTS
//  clk        in   1     clock, rising edge
//  reset      in   1     synchronous, active-high
//  DivStartE  in   1     EX holds a divide op (level; stays high while stalled)
//  DivOpE     in   2     funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//  SrcAE      in   32    dividend (forwarded rs1)
//  SrcBE      in   32    divisor (forwarded rs2)
//  FlushE     in   1     kill the EX-stage instruction (branch/jump)
//  StallDivE  out  1     freeze PC, IF/ID and ID/EX; combinational
//  DivDoneE   out  1     DivResultE valid this cycle; registered
//  DivResultE out  32    quotient or remainder; registered
// BEHAVIOUR
//  - Clock is clk; reset is synchronous, active-high.
//  - Reset: state=IDLE, DivDoneE=0, DivResultE=0, counter=0, internal regs=0.
//  - States: IDLE, BUSY, DONE.
//  - StallDivE = (IDLE & DivStartE & ~FlushE) | BUSY.
//  - IDLE, DivStartE=1, FlushE=0: latch op and operands.
//    - Special case: next state DONE, total latency 1 stall cycle.
//    - Otherwise: next state BUSY, counter=31.
//  - Special cases:
//    - SrcBE==0: quotient = 0xFFFFFFFF for DIV and DIVU; remainder = SrcAE.
//    - DIV/REM with SrcAE=0x80000000, SrcBE=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
//  - Signed ops: divide |A| by |B| unsigned.
//    - Negate the quotient if sign(A)^sign(B).
//    - Negate the remainder if sign(A); the remainder takes the dividend's sign.
//  - BUSY: one shift/subtract step per cycle; counter decrements.
//    - On counter==0: apply sign fix, load DivResultE, next state DONE.
//    - Normal op: 32 BUSY cycles, 33 stall cycles total.
//  - DONE: DivDoneE=1 for exactly one cycle and StallDivE=0, so the instruction moves to EX/MEM.
//    - Next state IDLE unconditionally; DivStartE is ignored in DONE (no self-restart).
//  - FlushE, any state: next state IDLE, DivDoneE=0 next cycle, StallDivE=0 immediately.
//    - FlushE has priority over DivStartE.
//  - DivDoneE is 0 in IDLE and BUSY. DivResultE holds its last value outside DONE.
//  - Back-to-back divides: the second starts in the IDLE cycle after DONE.
//  - Reset mid-BUSY: same as power-up reset; no partial result leaks out.
// CONFIGURATION
//  DIV_REM_CACHE_EN defined:
//    - Stores last completed {A, B, signed, quotient, remainder} with a valid bit.
//    - In IDLE, start with matching A, B and signedness while valid: go to DONE in 1 stall cycle,
//      returning the cached quotient or remainder per op. This covers DIV->REM fusion.
//    - Valid is cleared by reset only. Flushed or incomplete ops never update the cache.
//  DIV_REM_CACHE_EN undefined: no cache logic; every non-special op takes 33 stall cycles.
// STRUCTURE
//  - Shared package rv32im_pkg:
//    - DIV op encodings DIV_OP_DIV/DIVU/REM/REMU.
//    - div_state_t {IDLE, BUSY, DONE}.
//    - XLEN constant.
//  - Sub-module div_restoring_step (combinational):
//    - Inputs {rem, quo} and divisor; outputs the next {rem, quo} after one restoring step.
//  - Sign handling, special-case detection, FSM and cache stay in div_unit.
// TESTING
//  - DIVU 100/7: StallDivE high 33 cycles; DivDoneE 1 cycle; result 14. REMU 100/7 -> 2.
//  - DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1).
//    - REM 7/-2 -> 1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 after 1 stall cycle.
//  - Divide by zero: DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each after 1 stall cycle.
//  - Flush at BUSY cycle 10: next cycle IDLE, StallDivE=0, DivDoneE never asserted.
//    - A following DIVU 9/3 -> 3 after the full 33 cycles.
//  - Reset asserted mid-BUSY: all outputs 0 next cycle; hold DivStartE: a fresh 33-cycle op runs.
//  - With DIV_REM_CACHE_EN: DIV 1000/33 (33 cycles, ->30), then REM 1000/33 -> 10 in 1 stall cycle.
//    - Without the macro the same REM takes 33 cycles.

Source files
------------

// File: rtl/rv32im_pkg.sv
// rtl/rv32im_pkg.sv - shared RV32IM constants, divider op encodings and FSM state type
package rv32im_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Magnitude of v when it is treated as signed; unsigned operands pass through.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_restoring_step.sv
// rtl/div_restoring_step.sv - one radix-2 restoring division step on {rem, quo}
module div_restoring_step
    import rv32im_pkg::*;
(
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // rem < divisor always holds, so the shifted partial remainder fits in XLEN+1 bits.
    assign shifted = {rem_in, quo_in[XLEN-1]};
    assign diff    = shifted - {1'b0, divisor};

    assign rem_out = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_out = {quo_in[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative RV32M divider for EX; optional result cache under DIV_REM_CACHE_EN
module div_unit
    import rv32im_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            DivStartE,
    input  logic [1:0]      DivOpE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            FlushE,
    output logic            StallDivE,
    output logic            DivDoneE,
    output logic [XLEN-1:0] DivResultE
);

    div_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] rem_q, quo_q, divisor_q;
    logic [XLEN-1:0] rem_n, quo_n;
    logic [1:0]      op_q;
    logic            neg_q_q, neg_r_q;
    logic            done_q;
    logic [XLEN-1:0] result_q, result_d;
    logic            load_res, start_busy, cache_upd;

    logic            op_signed, sign_a, sign_b;
    logic            div_zero, overflow, special;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] q_fix, r_fix, final_res;
    logic            cache_hit;
    logic [XLEN-1:0] cache_res;

    assign op_signed = ~DivOpE[0];
    assign sign_a    = op_signed & SrcAE[XLEN-1];
    assign sign_b    = op_signed & SrcBE[XLEN-1];
    assign div_zero  = (SrcBE == '0);
    assign overflow  = op_signed && (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) && (SrcBE == '1);
    assign special   = div_zero | overflow;

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = DivOpE[1] ? SrcAE : '1;
        else
            special_res = DivOpE[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    div_restoring_step u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (divisor_q),
        .rem_out (rem_n),
        .quo_out (quo_n)
    );

    // The remainder follows the dividend's sign; the quotient follows sign(A)^sign(B).
    assign q_fix     = neg_q_q ? (~quo_n + 1'b1) : quo_n;
    assign r_fix     = neg_r_q ? (~rem_n + 1'b1) : rem_n;
    assign final_res = op_q[1] ? r_fix : q_fix;

`ifdef DIV_REM_CACHE_EN
    logic            cache_valid;
    logic [XLEN-1:0] cache_a, cache_b, cache_quo, cache_rem;
    logic            cache_signed;
    logic [XLEN-1:0] a_q, b_q;
    logic            signed_q;

    assign cache_hit = cache_valid && (SrcAE == cache_a) && (SrcBE == cache_b) &&
                       (op_signed == cache_signed);
    assign cache_res = DivOpE[1] ? cache_rem : cache_quo;

    always_ff @(posedge clk) begin
        if (reset) begin
            cache_valid  <= 1'b0;
            cache_a      <= '0;
            cache_b      <= '0;
            cache_quo    <= '0;
            cache_rem    <= '0;
            cache_signed <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            signed_q     <= 1'b0;
        end else begin
            if (start_busy) begin
                a_q      <= SrcAE;
                b_q      <= SrcBE;
                signed_q <= op_signed;
            end
            if (cache_upd) begin
                cache_valid  <= 1'b1;
                cache_a      <= a_q;
                cache_b      <= b_q;
                cache_signed <= signed_q;
                cache_quo    <= q_fix;
                cache_rem    <= r_fix;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_res = '0;
`endif

    always_comb begin
        state_d    = state_q;
        StallDivE  = 1'b0;
        load_res   = 1'b0;
        result_d   = result_q;
        start_busy = 1'b0;
        cache_upd  = 1'b0;
        case (state_q)
            IDLE: begin
                if (DivStartE) begin
                    StallDivE = 1'b1;
                    if (special) begin
                        state_d  = DONE;
                        load_res = 1'b1;
                        result_d = special_res;
                    end else if (cache_hit) begin
                        state_d  = DONE;
                        load_res = 1'b1;
                        result_d = cache_res;
                    end else begin
                        state_d    = BUSY;
                        start_busy = 1'b1;
                    end
                end
            end
            BUSY: begin
                StallDivE = 1'b1;
                if (cnt_q == '0) begin
                    state_d   = DONE;
                    load_res  = 1'b1;
                    result_d  = final_res;
                    cache_upd = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A killed instruction must never complete or touch the cache.
        if (FlushE) begin
            state_d    = IDLE;
            StallDivE  = 1'b0;
            load_res   = 1'b0;
            start_busy = 1'b0;
            cache_upd  = 1'b0;
        end
        if (reset)
            StallDivE = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            op_q      <= DIV_OP_DIV;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == DONE);
            if (load_res)
                result_q <= result_d;
            if (start_busy) begin
                rem_q     <= '0;
                quo_q     <= abs_val(SrcAE, op_signed);
                divisor_q <= abs_val(SrcBE, op_signed);
                cnt_q     <= CNT_W'(XLEN - 1);
                op_q      <= DivOpE;
                neg_q_q   <= sign_a ^ sign_b;
                neg_r_q   <= sign_a;
            end else if (state_q == BUSY) begin
                rem_q <= rem_n;
                quo_q <= quo_n;
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign DivDoneE   = done_q;
    assign DivResultE = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit against a latency/arithmetic reference model
module tb_div_unit;

`ifdef DIV_REM_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif
    localparam int PAIR_LAT = CACHE_ON ? 1 : 33;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        DivStartE = 1'b0;
    logic [1:0]  DivOpE = 2'b00;
    logic [31:0] SrcAE = '0;
    logic [31:0] SrcBE = '0;
    logic        FlushE = 1'b0;
    logic        StallDivE;
    logic        DivDoneE;
    logic [31:0] DivResultE;

    int n_cmp = 0;
    int n_err = 0;

    div_unit dut (
        .clk        (clk),
        .reset      (reset),
        .DivStartE  (DivStartE),
        .DivOpE     (DivOpE),
        .SrcAE      (SrcAE),
        .SrcBE      (SrcBE),
        .FlushE     (FlushE),
        .StallDivE  (StallDivE),
        .DivDoneE   (DivDoneE),
        .DivResultE (DivResultE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the RV32M rules.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        int sa, sb;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'h0 : 32'h8000_0000;
        if (op[0]) return op[1] ? (a % b) : (a / b);
        sa = a;
        sb = b;
        return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Model: outstanding-op tracker with remaining busy cycles and a one-entry cache.
    bit          m_active = 0, m_done = 0, m_cv = 0, m_cs = 0, m_ps = 0;
    int          m_left = 0;
    logic [31:0] m_res = '0, m_pend = '0, m_ca = '0, m_cb = '0, m_pa = '0, m_pb = '0;
    bit          cmp_en = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_active <= 0;
            m_done   <= 0;
            m_res    <= '0;
            m_cv     <= 0;
        end else if (m_done) begin
            m_done <= 0;
        end else if (m_active) begin
            if (FlushE) m_active <= 0;
            else if (m_left == 1) begin
                m_active <= 0;
                m_done   <= 1;
                m_res    <= m_pend;
                m_cv     <= 1;
                m_ca     <= m_pa;
                m_cb     <= m_pb;
                m_cs     <= m_ps;
            end else m_left <= m_left - 1;
        end else if (DivStartE && !FlushE) begin
            if (is_special(DivOpE, SrcAE, SrcBE) ||
                (CACHE_ON && m_cv && SrcAE == m_ca && SrcBE == m_cb && m_cs == !DivOpE[0])) begin
                m_done <= 1;
                m_res  <= ref_result(DivOpE, SrcAE, SrcBE);
            end else begin
                m_active <= 1;
                m_left   <= 32;
                m_pend   <= ref_result(DivOpE, SrcAE, SrcBE);
                m_pa     <= SrcAE;
                m_pb     <= SrcBE;
                m_ps     <= !DivOpE[0];
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_stall", {31'b0, StallDivE},
                {31'b0, !reset && !FlushE && (m_active || (!m_done && DivStartE))});
            chk("cyc_done", {31'b0, DivDoneE}, {31'b0, m_done});
            chk("cyc_result", DivResultE, m_res);
        end
    end

    task automatic wait_done(input logic [31:0] exp_res, input int exp_stall, input string name);
        int          stalls;
        logic        got;
        logic [31:0] res;
        stalls = 0;
        got    = 0;
        res    = '0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            if (StallDivE) stalls++;
            if (DivDoneE) begin
                got = 1;
                res = DivResultE;
            end
        end
        #1 DivStartE = 0;
        chk({name, " done_seen"}, {31'b0, got}, 32'd1);
        chk({name, " result"}, res, exp_res);
        chk({name, " stall_cycles"}, stalls, exp_stall);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_stall, input string name);
        @(posedge clk);
        #2;
        DivStartE = 1;
        DivOpE    = op;
        SrcAE     = a;
        SrcBE     = b;
        wait_done(exp_res, exp_stall, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        cmp_en = 1;
        @(negedge clk);
        chk("reset_done", {31'b0, DivDoneE}, 32'd0);
        chk("reset_result", DivResultE, 32'd0);
        chk("reset_stall", {31'b0, StallDivE}, 32'd0);
        @(posedge clk);
        #2 reset = 0;

        run_op(2'b01, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
        run_op(2'b11, 32'd100, 32'd7, 32'd2, PAIR_LAT, "remu_100_7");
        run_op(2'b00, -32'sd7, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2");
        run_op(2'b10, -32'sd7, 32'd2, 32'hFFFF_FFFF, PAIR_LAT, "rem_m7_2");
        run_op(2'b10, 32'd7, -32'sd2, 32'd1, 33, "rem_7_m2");
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, "rem_ovf");
        run_op(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
        run_op(2'b11, 32'd5, 32'd0, 32'd5, 1, "remu_by0");
        run_op(2'b00, -32'sd9, 32'd0, 32'hFFFF_FFFF, 1, "div_by0");
        run_op(2'b00, 32'd1000, 32'd33, 32'd30, 33, "div_1000_33");
        run_op(2'b10, 32'd1000, 32'd33, 32'd10, PAIR_LAT, "rem_1000_33");
        run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, "divu_max_1");
        run_op(2'b00, -32'sd100, -32'sd7, 32'd14, 33, "div_m100_m7");
        run_op(2'b10, -32'sd100, -32'sd7, 32'hFFFF_FFFE, PAIR_LAT, "rem_m100_m7");
        run_op(2'b11, 32'd7, 32'd100, 32'd7, 33, "remu_7_100");

        // Flush during the 10th BUSY cycle.
        @(posedge clk);
        #2;
        DivStartE = 1;
        DivOpE    = 2'b01;
        SrcAE     = 32'd1000;
        SrcBE     = 32'd7;
        repeat (10) @(posedge clk);
        #2 FlushE = 1;
        @(negedge clk);
        chk("flush_stall_now", {31'b0, StallDivE}, 32'd0);
        @(posedge clk);
        #2;
        FlushE    = 0;
        DivStartE = 0;
        @(negedge clk);
        chk("flush_stall_next", {31'b0, StallDivE}, 32'd0);
        chk("flush_done_next", {31'b0, DivDoneE}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("flush_no_done", {31'b0, DivDoneE}, 32'd0);
        end
        run_op(2'b01, 32'd9, 32'd3, 32'd3, 33, "divu_9_3");

        // Reset in the middle of BUSY with DivStartE held.
        @(posedge clk);
        #2;
        DivStartE = 1;
        DivOpE    = 2'b01;
        SrcAE     = 32'd100;
        SrcBE     = 32'd7;
        repeat (15) @(posedge clk);
        #2 reset = 1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_done", {31'b0, DivDoneE}, 32'd0);
        chk("rst_mid_result", DivResultE, 32'd0);
        chk("rst_mid_stall", {31'b0, StallDivE}, 32'd0);
        @(posedge clk);
        #2 reset = 0;
        wait_done(32'd14, 33, "rst_restart");

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
